// File: rtl/mix_pkg.sv
// ----------------------------------------------------------------------------
// mix_pkg
// Shared constants and types for the MIX core-memory arbiter.
//   AW, DW            memory address / word width (4096 x 31)
//   STARVE_MAX        denied cycles before a pending slot outranks st/mov
//   RD_* / WR_*       requester bit positions in the rd_req / wr_req vectors
//   RD_SRC_DEFAULT    rd_src code for the default operand address
//   wsel_e            write-port winner selection
// ----------------------------------------------------------------------------
package mix_pkg;

  localparam int AW         = 12;
  localparam int DW         = 31;
  localparam int STARVE_MAX = 7;
  localparam int NREQ       = 4;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  // Read requesters, bit 0 highest priority.
  localparam int RD_FETCH = 0;
  localparam int RD_OUT   = 1;
  localparam int RD_MOV   = 2;
  localparam int RD_SRAM  = 3;

  localparam logic [2:0] RD_SRC_DEFAULT = 3'd4;

  // Write requesters, bit 0 highest priority.
  localparam int WR_ST   = 0;
  localparam int WR_MOV  = 1;
  localparam int WR_IN   = 2;
  localparam int WR_SRAM = 3;

  typedef enum logic [2:0] {
    WSEL_ST   = 3'd0,
    WSEL_MOV  = 3'd1,
    WSEL_IN   = 3'd2,
    WSEL_SRAM = 3'd3,
    WSEL_NONE = 3'd4
  } wsel_e;

endpackage

// File: rtl/mix_wr_slot.sv
// ----------------------------------------------------------------------------
// mix_wr_slot
// One deferred-write slot with its starvation counter. A live request that
// finds the slot empty is always taken: either it wins the write port this
// cycle or it is parked here. While parked, the slot (not the live request)
// is the candidate presented to the write selector.
//   clk, reset_n      clock, async active-low reset
//   live_req/addr/data  requester's current write request
//   issue             this source won the write port this cycle
//   cand_valid/addr/data  candidate offered to the write selector
//   boost             slot has waited STARVE_MAX cycles; outranks st/mov
//   take              live request accepted this cycle (drives wr_ack)
//   busy              slot occupied
// ----------------------------------------------------------------------------
module mix_wr_slot
  import mix_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          live_req,
  input  logic [AW-1:0] live_addr,
  input  logic [DW-1:0] live_data,
  input  logic          issue,
  output logic          cand_valid,
  output logic [AW-1:0] cand_addr,
  output logic [DW-1:0] cand_data,
  output logic          boost,
  output logic          take,
  output logic          busy
);

  logic          valid;
  logic [AW-1:0] slot_addr;
  logic [DW-1:0] slot_data;
  logic [2:0]    starve_cnt;
  logic          capture;

  // An occupied slot issues before any new live request is considered.
  assign take       = live_req & ~valid;
  assign capture    = take & ~issue;
  assign cand_valid = valid | live_req;
  assign cand_addr  = valid ? slot_addr : live_addr;
  assign cand_data  = valid ? slot_data : live_data;
  assign boost      = valid & (starve_cnt == STARVE_LIM);
  assign busy       = valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid      <= 1'b0;
      starve_cnt <= '0;
    end else if (valid) begin
      if (issue) begin
        valid      <= 1'b0;
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 3'd1;
      end
    end else if (capture) begin
      valid      <= 1'b1;
      starve_cnt <= '0;
    end
  end

  // NOTE: payload registers are not reset; they are only observed while
  // valid is set, so a reset network on them would buy nothing.
  always_ff @(posedge clk) begin
    if (capture) begin
      slot_addr <= live_addr;
      slot_data <= live_data;
    end
  end

endmodule

// File: rtl/mix_mem_arb.sv
// ----------------------------------------------------------------------------
// mix_mem_arb
// Arbiter for the 4096x31 MIX core memory: one synchronous read port shared
// by fetch/out/mov/sram/default-operand, one write port shared by
// st/mov/in/sram, with deferred in/sram writes, bounded starvation and
// read-after-write forwarding.
//   clk, reset_n                 clock, async active-low reset
//   rd_req[4], rd_addr[4*AW]     read requests {sram,mov,out,fetch}
//   def_addr                     operand address when no read request
//   mem_raddr, rd_gnt            combinational read address / one-hot grant
//   rd_src                       registered source of the word on rd_data
//   mem_rdata, rd_data           memory output / forwarded read data
//   wr_req[4], wr_addr, wr_data  write requests {sram,in,mov,st}
//   wr_ack                       registered pulse: write issued or buffered
//   mem_we, mem_waddr, mem_wdata registered write port
//   wr_busy                      {sram,in} pending slot occupied
// ----------------------------------------------------------------------------
module mix_mem_arb
  import mix_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    rd_req,
  input  logic [NREQ*AW-1:0] rd_addr,
  input  logic [AW-1:0]      def_addr,
  output logic [AW-1:0]      mem_raddr,
  output logic [NREQ-1:0]    rd_gnt,
  output logic [2:0]         rd_src,
  input  logic [DW-1:0]      mem_rdata,
  output logic [DW-1:0]      rd_data,
  input  logic [NREQ-1:0]    wr_req,
  input  logic [NREQ*AW-1:0] wr_addr,
  input  logic [NREQ*DW-1:0] wr_data,
  output logic [NREQ-1:0]    wr_ack,
  output logic               mem_we,
  output logic [AW-1:0]      mem_waddr,
  output logic [DW-1:0]      mem_wdata,
  output logic [1:0]         wr_busy
);

  logic [2:0]    rd_sel;
  wsel_e         win;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;
  logic          we_next;
  logic          fwd_next;
  logic          fwd;
  logic [3:0]    ack_next;

  logic          in_cand,  sram_cand;
  logic [AW-1:0] in_addr,  sram_addr;
  logic [DW-1:0] in_data,  sram_data;
  logic          in_boost, sram_boost;
  logic          in_take,  sram_take;
  logic          in_busy,  sram_busy;

  // --------------------------------------------------------------------------
  // Read port: fixed priority, lowest index wins.
  // --------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before any condition so
  // no path leaves it unassigned (which would infer a latch).
  always_comb begin
    rd_gnt    = '0;
    mem_raddr = def_addr;
    rd_sel    = RD_SRC_DEFAULT;
    // Descending scan so the lowest set bit is the last (winning) assignment.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rd_req[i]) begin
        rd_gnt    = '0;
        rd_gnt[i] = 1'b1;
        mem_raddr = rd_addr[i*AW +: AW];
        rd_sel    = 3'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Deferred write slots.
  // --------------------------------------------------------------------------
  mix_wr_slot u_in_slot (
    .clk        (clk),
    .reset_n    (reset_n),
    .live_req   (wr_req[WR_IN]),
    .live_addr  (wr_addr[WR_IN*AW +: AW]),
    .live_data  (wr_data[WR_IN*DW +: DW]),
    .issue      (win == WSEL_IN),
    .cand_valid (in_cand),
    .cand_addr  (in_addr),
    .cand_data  (in_data),
    .boost      (in_boost),
    .take       (in_take),
    .busy       (in_busy)
  );

  mix_wr_slot u_sram_slot (
    .clk        (clk),
    .reset_n    (reset_n),
    .live_req   (wr_req[WR_SRAM]),
    .live_addr  (wr_addr[WR_SRAM*AW +: AW]),
    .live_data  (wr_data[WR_SRAM*DW +: DW]),
    .issue      (win == WSEL_SRAM),
    .cand_valid (sram_cand),
    .cand_addr  (sram_addr),
    .cand_data  (sram_data),
    .boost      (sram_boost),
    .take       (sram_take),
    .busy       (sram_busy)
  );

  // --------------------------------------------------------------------------
  // Write selector: a starved slot takes one issue ahead of st/mov.
  // --------------------------------------------------------------------------
  always_comb begin
    win = WSEL_NONE;
    if (in_boost)            win = WSEL_IN;
    else if (sram_boost)     win = WSEL_SRAM;
    else if (wr_req[WR_ST])  win = WSEL_ST;
    else if (wr_req[WR_MOV]) win = WSEL_MOV;
    else if (in_cand)        win = WSEL_IN;
    else if (sram_cand)      win = WSEL_SRAM;
  end

  always_comb begin
    win_addr = '0;
    win_data = '0;
    case (win)
      WSEL_ST: begin
        win_addr = wr_addr[WR_ST*AW +: AW];
        win_data = wr_data[WR_ST*DW +: DW];
      end
      WSEL_MOV: begin
        win_addr = wr_addr[WR_MOV*AW +: AW];
        win_data = wr_data[WR_MOV*DW +: DW];
      end
      WSEL_IN: begin
        win_addr = in_addr;
        win_data = in_data;
      end
      WSEL_SRAM: begin
        win_addr = sram_addr;
        win_data = sram_data;
      end
      default: ;
    endcase
  end

  assign we_next  = (win != WSEL_NONE);
  // A read of the word being issued would return the stale value next cycle;
  // flag it so rd_data takes the word from the write register instead.
  assign fwd_next = we_next && (mem_raddr == win_addr);
  // Slot sources ack on take (issue or capture); a slot issuing later is
  // not acked again.
  assign ack_next = {sram_take, in_take, win == WSEL_MOV, win == WSEL_ST};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      wr_ack    <= '0;
      rd_src    <= RD_SRC_DEFAULT;
      fwd       <= 1'b0;
    end else begin
      mem_we    <= we_next;
      mem_waddr <= win_addr;
      mem_wdata <= win_data;
      wr_ack    <= ack_next;
      rd_src    <= rd_sel;
      fwd       <= fwd_next;
    end
  end

  // mem_wdata still holds the forwarded word during the cycle after issue.
  assign rd_data = fwd ? mem_wdata : mem_rdata;
  assign wr_busy = {sram_busy, in_busy};

endmodule

// File: tb/tb_mix_mem_arb.sv
// ----------------------------------------------------------------------------
// tb_mix_mem_arb
// Directed scenarios plus randomized traffic against a cycle-level reference
// model. The model treats a write as visible to reads from the cycle it wins
// the port; the attached memory model is write-first.
// ----------------------------------------------------------------------------
module tb_mix_mem_arb;
  import mix_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NREQ-1:0]    rd_req;
  logic [NREQ*AW-1:0] rd_addr;
  logic [AW-1:0]      def_addr;
  logic [AW-1:0]      mem_raddr;
  logic [NREQ-1:0]    rd_gnt;
  logic [2:0]         rd_src;
  logic [DW-1:0]      mem_rdata;
  logic [DW-1:0]      rd_data;
  logic [NREQ-1:0]    wr_req;
  logic [NREQ*AW-1:0] wr_addr;
  logic [NREQ*DW-1:0] wr_data;
  logic [NREQ-1:0]    wr_ack;
  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic [DW-1:0]      mem_wdata;
  logic [1:0]         wr_busy;

  always #5 clk = ~clk;

  mix_mem_arb dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .def_addr  (def_addr),
    .mem_raddr (mem_raddr),
    .rd_gnt    (rd_gnt),
    .rd_src    (rd_src),
    .mem_rdata (mem_rdata),
    .rd_data   (rd_data),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .wr_busy   (wr_busy)
  );

  // Core memory: synchronous read, write-first on a same-address collision.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    mem_rdata <= (mem_we && mem_waddr == mem_raddr) ? mem_wdata : mem[mem_raddr];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [DW-1:0] ref_mem   [0:(1<<AW)-1];
  bit            ref_known [0:(1<<AW)-1];
  bit            sv   [2];          // pending slot occupied: 0=in, 1=sram
  int            sage [2];          // denied cycles while occupied
  logic [AW-1:0] sa   [2];
  logic [DW-1:0] sd   [2];
  logic          e_we;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_wdata;
  logic [3:0]    e_ack;
  logic [2:0]    e_src;
  bit            e_rd_ok;
  logic [DW-1:0] e_rd;
  int            last_win;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      sv[k]   = 1'b0;
      sage[k] = 0;
    end
    e_we     = 1'b0;
    e_ack    = '0;
    e_src    = RD_SRC_DEFAULT;
    e_rd_ok  = 1'b0;
    last_win = -1;
  endtask

  // Evaluate the current (settled) inputs: check combinational outputs and
  // predict the registered outputs after the coming edge.
  task automatic model_step();
    int            g;
    int            win;
    logic [AW-1:0] ra;
    logic [3:0]    exp_gnt;
    bit            cv [4];
    logic [AW-1:0] ca [4];
    logic [DW-1:0] cd [4];

    g = 4;
    for (int i = 3; i >= 0; i--) if (rd_req[i]) g = i;
    exp_gnt = '0;
    ra      = def_addr;
    if (g < 4) begin
      exp_gnt[g] = 1'b1;
      ra         = rd_addr[g*AW +: AW];
    end
    check("rd_gnt", rd_gnt, exp_gnt);
    check("mem_raddr", mem_raddr, ra);

    for (int i = 0; i < 4; i++) begin
      cv[i] = wr_req[i];
      ca[i] = wr_addr[i*AW +: AW];
      cd[i] = wr_data[i*DW +: DW];
    end
    for (int k = 0; k < 2; k++) begin
      if (sv[k]) begin
        cv[2+k] = 1'b1;
        ca[2+k] = sa[k];
        cd[2+k] = sd[k];
      end
    end

    win = -1;
    if (sv[0] && sage[0] >= STARVE_MAX)      win = 2;
    else if (sv[1] && sage[1] >= STARVE_MAX) win = 3;
    else for (int i = 3; i >= 0; i--) if (cv[i]) win = i;

    e_we  = (win >= 0);
    e_ack = '0;
    if (win >= 0) begin
      e_waddr            = ca[win];
      e_wdata            = cd[win];
      ref_mem[ca[win]]   = cd[win];
      ref_known[ca[win]] = 1'b1;
    end
    if (win == 0) e_ack[0] = 1'b1;
    if (win == 1) e_ack[1] = 1'b1;

    for (int k = 0; k < 2; k++) begin
      if (sv[k]) begin
        if (win == 2 + k) begin
          sv[k]   = 1'b0;
          sage[k] = 0;
        end else if (sage[k] < STARVE_MAX) begin
          sage[k]++;
        end
      end else if (wr_req[2+k]) begin
        e_ack[2+k] = 1'b1;
        if (win != 2 + k) begin
          sv[k]   = 1'b1;
          sage[k] = 0;
          sa[k]   = ca[2+k];
          sd[k]   = cd[2+k];
        end
      end
    end

    e_src    = 3'(g);
    e_rd_ok  = ref_known[ra];
    e_rd     = ref_mem[ra];
    last_win = win;
  endtask

  task automatic post_check();
    check("mem_we", mem_we, e_we);
    if (e_we) begin
      check("mem_waddr", mem_waddr, e_waddr);
      check("mem_wdata", mem_wdata, e_wdata);
    end
    check("wr_ack", wr_ack, e_ack);
    check("wr_busy", wr_busy, {sv[1], sv[0]});
    check("rd_src", rd_src, e_src);
    if (e_rd_ok) check("rd_data", rd_data, e_rd);
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic cycle();
    #1;
    model_step();
    @(posedge clk);
    @(negedge clk);
    post_check();
  endtask

  task automatic clear_inputs();
    rd_req  = '0;
    rd_addr = '0;
    wr_req  = '0;
    wr_addr = '0;
    wr_data = '0;
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr[i*AW +: AW] = a;
    wr_data[i*DW +: DW] = d;
  endtask

  function automatic logic [AW-1:0] pool_addr();
    return 12'h040 + 12'($urandom_range(0, 15));
  endfunction

  // st/mov hold a request until they win; in/sram respect the busy flag
  // except for an occasional illegal request that must be ignored.
  task automatic drive_random(input int st_pct);
    rd_req   = 4'($urandom_range(0, 15));
    def_addr = pool_addr();
    for (int i = 0; i < 4; i++) rd_addr[i*AW +: AW] = pool_addr();
    for (int i = 0; i < 2; i++) begin
      if (!wr_req[i] || last_win == i) begin
        wr_req[i] = ($urandom_range(0, 99) < ((i == 0) ? st_pct : 30));
        set_wr(i, pool_addr(), 31'($urandom));
      end
    end
    for (int k = 0; k < 2; k++) begin
      wr_req[2+k] = sv[k] ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
      set_wr(2 + k, pool_addr(), 31'($urandom));
    end
  endtask

  initial begin
    int  n;
    bit  found;

    for (int a = 0; a < (1 << AW); a++) ref_known[a] = 1'b0;
    clear_inputs();
    def_addr = 12'h000;
    reset_n  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_wr_ack", wr_ack, 4'b0000);
    check("rst_wr_busy", wr_busy, 2'b00);
    check("rst_rd_src", rd_src, RD_SRC_DEFAULT);
    reset_n = 1'b1;

    // Idle: default address, default source, no write.
    def_addr = 12'h3C1;
    cycle();
    cycle();
    check("idle_src", rd_src, RD_SRC_DEFAULT);
    check("idle_we", mem_we, 1'b0);

    // Read priority: out beats mov.
    rd_req = 4'b0110;
    rd_addr[RD_OUT*AW +: AW] = 12'h010;
    rd_addr[RD_MOV*AW +: AW] = 12'h020;
    #1;
    check("prio_raddr", mem_raddr, 12'h010);
    check("prio_gnt", rd_gnt, 4'b0010);
    cycle();
    check("prio_src", rd_src, 3'd1);

    // Write contention: st wins, in is buffered and issues next.
    clear_inputs();
    wr_req = 4'b0101;
    set_wr(WR_ST, 12'h100, 31'h0000_1111);
    set_wr(WR_IN, 12'h200, 31'h0000_2222);
    cycle();
    check("cont_st_waddr", mem_waddr, 12'h100);
    check("cont_in_ack", wr_ack[WR_IN], 1'b1);
    check("cont_in_busy", wr_busy[0], 1'b1);
    clear_inputs();
    cycle();
    check("cont_in_we", mem_we, 1'b1);
    check("cont_in_waddr", mem_waddr, 12'h200);
    cycle();

    // Forward: read the address being issued.
    rd_req = 4'b0001;
    rd_addr[RD_FETCH*AW +: AW] = 12'h0A5;
    wr_req = 4'b0001;
    set_wr(WR_ST, 12'h0A5, 31'h12345);
    cycle();
    check("fwd_rd_data", rd_data, 31'h12345);
    clear_inputs();
    cycle();

    // Starvation: sram parked while st writes every cycle.
    wr_req = 4'b1001;
    set_wr(WR_ST, 12'h300, 31'h0000_0300);
    set_wr(WR_SRAM, 12'h777, 31'h0777_0777);
    cycle();
    n     = 0;
    found = 1'b0;
    for (int it = 0; it < 30 && !found; it++) begin
      wr_req = 4'b0001;
      set_wr(WR_ST, 12'h301 + 12'(it), 31'(it));
      cycle();
      n++;
      if (mem_we && mem_waddr == 12'h777) found = 1'b1;
    end
    check("starve_denied", n - 1, STARVE_MAX);
    clear_inputs();
    repeat (2) cycle();

    // Reset while the in slot holds a write.
    wr_req = 4'b0101;
    set_wr(WR_ST, 12'h110, 31'h0000_0110);
    set_wr(WR_IN, 12'h210, 31'h0000_0210);
    cycle();
    check("rstmid_busy_pre", wr_busy[0], 1'b1);
    clear_inputs();
    reset_n = 1'b0;
    #1;
    check("rstmid_busy", wr_busy, 2'b00);
    check("rstmid_we", mem_we, 1'b0);
    if (e_we) ref_known[e_waddr] = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      cycle();
      check("rstmid_no_stale", mem_we, 1'b0);
    end

    // Randomized traffic: moderate, then st-heavy to provoke boosts.
    clear_inputs();
    repeat (1500) begin
      drive_random(30);
      cycle();
    end
    repeat (1500) begin
      drive_random(95);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
